// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-cache and D-cache: one 4-word line
// transaction at a time, D-cache favoured, with a streak cap so I is not starved.
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_read,
  input  logic [15:0]            i_addr,
  output logic [4*WORD_SIZE-1:0] i_rdata,
  output logic                   i_done,
  input  logic                   d_read,
  input  logic                   d_write,
  input  logic [15:0]            d_addr,
  input  logic [4*WORD_SIZE-1:0] d_wdata,
  output logic [4*WORD_SIZE-1:0] d_rdata,
  output logic                   d_done,
  output logic                   mem_readM,
  output logic                   mem_writeM,
  output logic [15:0]            mem_addr,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  output logic [15:0]            num_mem_access
);
  // state | meaning
  // IDLE  | sample requests, pick a winner, launch strobe
  // BUSY  | strobe held, latency counter running down
  // DONE  | owner's done pulse high for this one cycle
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STK_W = $clog2(MAX_D_STREAK + 1);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [STK_W-1:0] streak;
  logic             own_d;
  logic             d_req;
  logic             grant_d;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_read | (streak != STK_W'(MAX_D_STREAK)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      streak         <= '0;
      own_d          <= 1'b0;
      i_rdata        <= '0;
      i_done         <= 1'b0;
      d_rdata        <= '0;
      d_done         <= 1'b0;
      mem_readM      <= 1'b0;
      mem_writeM     <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      num_mem_access <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req || i_read) begin
            own_d   <= grant_d;
            lat_cnt <= LAT_W'(MEM_LATENCY - 1);
            state   <= BUSY;
            if (grant_d) begin
              mem_addr <= {d_addr[15:2], 2'b00};
              // a simultaneous read+write is a write-back; the fill follows later
              mem_writeM <= d_write;
              mem_readM  <= ~d_write;
              if (d_write)
                mem_wdata <= d_wdata;
              streak <= i_read ? streak + STK_W'(1) : '0;
            end else begin
              mem_addr   <= {i_addr[15:2], 2'b00};
              mem_readM  <= 1'b1;
              mem_writeM <= 1'b0;
              streak     <= '0;
            end
          end
        end
        BUSY: begin
          if (lat_cnt == '0) begin
            mem_readM      <= 1'b0;
            mem_writeM     <= 1'b0;
            num_mem_access <= num_mem_access + 16'd1;
            state          <= DONE;
            if (own_d) begin
              d_done <= 1'b1;
              if (!mem_writeM)
                d_rdata <= mem_rdata;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        DONE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LATENCY=2, MAX_D_STREAK=4.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_read, d_read, d_write;
  logic [15:0] i_addr, d_addr;
  logic [63:0] d_wdata, mem_rdata;
  logic [63:0] i_rdata, d_rdata, mem_wdata;
  logic        i_done, d_done, mem_readM, mem_writeM;
  logic [15:0] mem_addr, num_mem_access;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .num_mem_access(num_mem_access)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #1;
    chk("rst_readM", mem_readM, 0);
    chk("rst_writeM", mem_writeM, 0);
    chk("rst_done", {i_done, d_done}, 0);
    chk("rst_count", num_mem_access, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // 1: lone I-cache fill
    i_read = 1; i_addr = 16'h1235; mem_rdata = 64'hA5A5_0001_A5A5_0002;
    tick();
    chk("t1_c1_readM", mem_readM, 1);
    chk("t1_c1_writeM", mem_writeM, 0);
    chk("t1_addr", mem_addr, 16'h1234);
    i_read = 0;
    tick();
    chk("t1_c2_readM", mem_readM, 1);
    chk("t1_c2_idone", i_done, 0);
    tick();
    chk("t1_c3_readM", mem_readM, 0);
    chk("t1_c3_idone", i_done, 1);
    chk("t1_c3_ddone", d_done, 0);
    chk("t1_rdata", i_rdata, 64'hA5A5_0001_A5A5_0002);
    tick();
    chk("t1_idle_idone", i_done, 0);

    // 2: D-cache write-back
    d_write = 1; d_addr = 16'h00A7; d_wdata = 64'h1111_2222_3333_4444;
    tick();
    chk("t2_writeM", mem_writeM, 1);
    chk("t2_readM", mem_readM, 0);
    chk("t2_addr", mem_addr, 16'h00A4);
    chk("t2_wdata", mem_wdata, 64'h1111_2222_3333_4444);
    d_write = 0;
    tick();
    chk("t2_c2_writeM", mem_writeM, 1);
    tick();
    chk("t2_c3_writeM", mem_writeM, 0);
    chk("t2_ddone", d_done, 1);
    chk("t2_drdata", d_rdata, 0);
    tick();
    chk("t2_count", num_mem_access, 2);

    // 3: simultaneous I and D fills, D first
    i_read = 1; i_addr = 16'h0010; d_read = 1; d_addr = 16'h0020;
    mem_rdata = 64'hDDDD_0000_0000_0001;
    tick();
    chk("t3_d_addr", mem_addr, 16'h0020);
    chk("t3_d_readM", mem_readM, 1);
    d_read = 0;
    tick(); tick();
    chk("t3_ddone", d_done, 1);
    chk("t3_drdata", d_rdata, 64'hDDDD_0000_0000_0001);
    mem_rdata = 64'h1111_0000_0000_0002;
    tick();
    chk("t3_gap_readM", mem_readM, 0);
    tick();
    chk("t3_i_addr", mem_addr, 16'h0010);
    chk("t3_i_readM", mem_readM, 1);
    i_read = 0;
    tick(); tick();
    chk("t3_idone", i_done, 1);
    chk("t3_irdata", i_rdata, 64'h1111_0000_0000_0002);
    tick();

    // 4: streak cap: D,D,D,D,I,D
    i_read = 1; i_addr = 16'h0100; d_read = 1; d_addr = 16'h0200;
    mem_rdata = 64'h3333_3333_3333_3333;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t4_grant%0d", k), mem_addr, (k == 4) ? 16'h0100 : 16'h0200);
      tick(); tick();
      chk($sformatf("t4_done%0d", k), {i_done, d_done}, (k == 4) ? 2'b10 : 2'b01);
      if (k == 4) i_read = 0;
      if (k == 5) d_read = 0;
      tick();
    end

    // 5: read and write together act as a write
    d_read = 1; d_write = 1; d_addr = 16'h0333; d_wdata = 64'h5555_6666_7777_8888;
    mem_rdata = 64'h9999_9999_9999_9999;
    tick();
    chk("t5_writeM", mem_writeM, 1);
    chk("t5_readM", mem_readM, 0);
    chk("t5_addr", mem_addr, 16'h0330);
    d_read = 0; d_write = 0;
    tick(); tick();
    chk("t5_ddone", d_done, 1);
    chk("t5_drdata", d_rdata, 64'h3333_3333_3333_3333);
    tick();
    chk("t5_count", num_mem_access, 11);

    // 6: reset in the first BUSY cycle
    i_read = 1; i_addr = 16'h0044;
    tick();
    chk("t6_busy_readM", mem_readM, 1);
    i_read = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_readM", mem_readM, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_count", num_mem_access, 0);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6_post%0d", k), {mem_readM, mem_writeM, i_done, d_done}, 0);
    end
    chk("t6_post_count", num_mem_access, 0);
    d_read = 1; d_addr = 16'h0808;
    tick();
    chk("t6_idle_grant", {mem_readM, mem_addr}, {1'b1, 16'h0808});
    d_read = 0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
